// File: rtl/mult_wb_pkg.sv
// Shared register map and types for the 4-bit multiplier Wishbone master/slave pair.
package mult_wb_pkg;

  // Select bits (one-hot register select on sel)
  localparam int unsigned SEL_CONTROL = 0;
  localparam int unsigned SEL_DATA_IN = 1;

  // Field positions inside the 32-bit data word
  localparam int unsigned EN_BIT  = 0;
  localparam int unsigned A_LSB   = 8;
  localparam int unsigned B_LSB   = 12;
  localparam int unsigned Y_LSB   = 16;
  localparam int unsigned FIM_BIT = 24;

  // Field widths
  localparam int unsigned OP_W = 4;
  localparam int unsigned Y_W  = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_AB,
    ST_WR_EN,
    ST_POLL,
    ST_CLR,
    ST_GAP,
    ST_DONE
  } mult_wb_state_t;

  // Operand pair as written to the data-in register
  typedef struct packed {
    logic [OP_W-1:0] b;
    logic [OP_W-1:0] a;
  } mult_ops_t;

endpackage

// File: rtl/wb_access_timer.sv
// Ack-timeout counter: counts strobe cycles without ack, flags the last allowed one.
module wb_access_timer #(
  parameter int unsigned LIMIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired_c
);

  localparam int unsigned CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_q;

  // High during the LIMIT-th strobe cycle still waiting for ack
  assign expired_c = (cnt_q == CW'(LIMIT - 1));

  // Wait-cycle counter, restarted whenever the strobe is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && !expired_c) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/mult_wb_master.sv
// Wishbone master sequencing one multiply on the 4-bit multiplier register slave.
module mult_wb_master
  import mult_wb_pkg::*;
#(
  parameter int unsigned BUS_WIDTH   = 1,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned BE_WIDTH    = 4,
  parameter int unsigned ACK_TIMEOUT = 16,
  parameter int unsigned POLL_MAX    = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  output logic [BUS_WIDTH-1:0]  adr_o,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  we_o,
  output logic [BE_WIDTH-1:0]   sel_o,
  output logic                  stb_o,
  input  logic                  ack_i,
  input  logic                  start_i,
  input  logic [OP_W-1:0]       a_i,
  input  logic [OP_W-1:0]       b_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [Y_W-1:0]        y_o,
  output logic                  err_o
);

  localparam int unsigned PW = $clog2(POLL_MAX + 1);

  localparam logic [BE_WIDTH-1:0] SEL_AB  = BE_WIDTH'(1) << SEL_DATA_IN;
  localparam logic [BE_WIDTH-1:0] SEL_CTL = BE_WIDTH'(1) << SEL_CONTROL;
  localparam logic [DATA_WIDTH-1:0] EN_WORD = DATA_WIDTH'(1) << EN_BIT;

  mult_wb_state_t state_q, nxt_state;
  mult_wb_state_t ret_q, nxt_ret;

  logic [PW-1:0]         poll_q, nxt_poll, poll_inc;
  logic                  err_pend_q, nxt_err_pend;
  logic                  nxt_stb, nxt_we, nxt_busy, nxt_done, nxt_err;
  logic [BE_WIDTH-1:0]   nxt_sel;
  logic [DATA_WIDTH-1:0] nxt_data;
  logic [Y_W-1:0]        nxt_y;
  logic                  tmr_clr_c, tmr_en_c, tmr_expired_c;
  logic                  unused_data;

  // Operand write word: A and B in their fields, everything else zero
  function automatic logic [DATA_WIDTH-1:0] ab_word(input mult_ops_t ops);
    logic [DATA_WIDTH-1:0] w;
    w = '0;
    w[A_LSB +: OP_W] = ops.a;
    w[B_LSB +: OP_W] = ops.b;
    return w;
  endfunction

  // Slave decodes by sel only
  assign adr_o = '0;

  // Only the Y and fim fields of the status word are consumed
  assign unused_data = ^data_i;

  // Timer runs while a strobe waits for ack, restarts in every strobe-low cycle
  assign tmr_clr_c = !stb_o;
  assign tmr_en_c  = stb_o && !ack_i;

  wb_access_timer #(
    .LIMIT (ACK_TIMEOUT)
  ) u_timer (
    .clk       (clk_i),
    .rst_n     (rst_i),
    .clr       (tmr_clr_c),
    .en        (tmr_en_c),
    .expired_c (tmr_expired_c)
  );

  // State and registered outputs
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= ST_IDLE;
      ret_q      <= ST_IDLE;
      poll_q     <= '0;
      err_pend_q <= 1'b0;
      stb_o      <= 1'b0;
      we_o       <= 1'b0;
      sel_o      <= '0;
      data_o     <= '0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      y_o        <= '0;
      err_o      <= 1'b0;
    end else begin
      state_q    <= nxt_state;
      ret_q      <= nxt_ret;
      poll_q     <= nxt_poll;
      err_pend_q <= nxt_err_pend;
      stb_o      <= nxt_stb;
      we_o       <= nxt_we;
      sel_o      <= nxt_sel;
      data_o     <= nxt_data;
      busy_o     <= nxt_busy;
      done_o     <= nxt_done;
      y_o        <= nxt_y;
      err_o      <= nxt_err;
    end
  end

  // Next state and next output values
  always_comb begin
    nxt_state    = state_q;
    nxt_ret      = ret_q;
    nxt_poll     = poll_q;
    nxt_err_pend = err_pend_q;
    nxt_stb      = stb_o;
    nxt_we       = we_o;
    nxt_sel      = sel_o;
    nxt_data     = data_o;
    nxt_busy     = busy_o;
    nxt_done     = 1'b0;
    nxt_y        = y_o;
    nxt_err      = err_o;
    poll_inc     = poll_q + PW'(1);

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          nxt_err      = 1'b0;
          nxt_err_pend = 1'b0;
          nxt_poll     = '0;
          nxt_busy     = 1'b1;
          nxt_state    = ST_WR_AB;
          nxt_stb      = 1'b1;
          nxt_we       = 1'b1;
          nxt_sel      = SEL_AB;
          nxt_data     = ab_word('{b: b_i, a: a_i});
        end
      end

      ST_WR_AB, ST_WR_EN, ST_POLL, ST_CLR: begin
        if (ack_i) begin
          nxt_stb  = 1'b0;
          nxt_we   = 1'b0;
          nxt_sel  = '0;
          nxt_data = '0;
          nxt_state = ST_GAP;
          case (state_q)
            ST_WR_AB: nxt_ret = ST_WR_EN;
            ST_WR_EN: nxt_ret = ST_POLL;
            ST_POLL: begin
              nxt_poll = poll_inc;
              if (data_i[FIM_BIT]) begin
                nxt_y   = data_i[Y_LSB +: Y_W];
                nxt_ret = ST_CLR;
              end else if (poll_inc == PW'(POLL_MAX)) begin
                nxt_err_pend = 1'b1;
                nxt_ret      = ST_CLR;
              end else begin
                nxt_ret = ST_POLL;
              end
            end
            default: begin
              // Clear write acknowledged: sequence complete
              nxt_state = ST_DONE;
              nxt_done  = 1'b1;
              nxt_err   = err_pend_q;
            end
          endcase
        end else if (tmr_expired_c) begin
          // Slave never answered: abandon without the clear write
          nxt_stb   = 1'b0;
          nxt_we    = 1'b0;
          nxt_sel   = '0;
          nxt_data  = '0;
          nxt_state = ST_DONE;
          nxt_done  = 1'b1;
          nxt_err   = 1'b1;
        end
      end

      ST_GAP: begin
        nxt_state = ret_q;
        nxt_stb   = 1'b1;
        case (ret_q)
          ST_WR_EN: begin
            nxt_we   = 1'b1;
            nxt_sel  = SEL_CTL;
            nxt_data = EN_WORD;
          end
          ST_POLL: begin
            nxt_we   = 1'b0;
            nxt_sel  = '0;
            nxt_data = '0;
          end
          default: begin
            nxt_we   = 1'b1;
            nxt_sel  = SEL_CTL;
            nxt_data = '0;
          end
        endcase
      end

      ST_DONE: begin
        nxt_busy  = 1'b0;
        nxt_state = ST_IDLE;
      end

      default: begin
        nxt_state = ST_IDLE;
      end
    endcase
  end

endmodule
